wb_master_seq: RTL and testbench
================================

Name: wb_master_seq

Overview:
Synthesizable, command-driven Wishbone classic master. A command FIFO accepts single-beat read/write requests; a sequencer issues them on the bus, retries on rty_i, enforces a timeout watchdog and returns one response per command. Locked sequences (cyc_o held across commands) are supported. Replaces task-based bus driving in benches and serves as an on-chip bus initiator for register programming of the I2C core.

Parameters:
AW, 32, address width
DW, 32, data width; multiple of 8
CMD_DEPTH, 4, command FIFO depth; power of 2, >=2
MAX_RETRY, 3, rty_i retries before giving up; 0 = no retry
RETRY_GAP, 2, idle cycles between retries; >=1
TIMEOUT, 64, cycles in REQ without termination before abort; 0 = disabled

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active low
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO not full
cmd_we  in  1  1 = write
cmd_hold  in  1  keep cyc_o asserted after this command (lock)
cmd_adr  in  AW  address
cmd_dat  in  DW  write data
cmd_sel  in  DW/8  byte selects
rsp_valid  out  1  response valid
rsp_ready  in  1  response accepted
rsp_dat  out  DW  read data; 0 for writes
rsp_status  out  2  00 ok, 01 err, 10 retry exhausted, 11 timeout
rsp_retries  out  clog2(MAX_RETRY+1), min 1  retries consumed
busy  out  1  FIFO non-empty or state != IDLE
adr_o, dat_o, sel_o, we_o, cyc_o, stb_o  out  AW/DW/DW/8/1/1/1  Wishbone master outputs
dat_i  in  DW  read data
ack_i, err_i, rty_i  in  1  slave terminations

Behaviour:
- Reset (async, rst_n=0): state IDLE, FIFO empty, all outputs 0 (cyc_o, stb_o, we_o, adr_o, dat_o, sel_o, rsp_*, busy); cmd_ready=1 one cycle after release. No X on outputs, ever.
- Command push on rising edge with cmd_valid & cmd_ready. Push while full is ignored (cmd_ready=0).
- States: IDLE, REQ, GAP, RESP.
- IDLE: FIFO non-empty -> pop, register head into bus outputs, cyc_o=stb_o=1 -> REQ. stb_o first high at the 2nd rising edge after the push edge (FIFO empty beforehand).
- REQ: termination priority err_i > rty_i > ack_i, sampled each edge.
  ack_i: stb_o=0; rsp_dat=dat_i if read, else 0; status 00 -> RESP.
  err_i: status 01 -> RESP; lock released.
  rty_i with retries<MAX_RETRY: retries++, cyc_o=stb_o=0 (cyc_o stays 1 if locked) -> GAP.
  rty_i with retries=MAX_RETRY: status 10 -> RESP; lock released.
  Timeout: watchdog counts edges in REQ, cleared on entry. Reaching TIMEOUT -> status 11 -> RESP; lock released.
- GAP: hold RETRY_GAP cycles, then reassert with the same command -> REQ.
- RESP: rsp_valid=1, stable until rsp_ready. On handshake -> IDLE and next command may start the following edge.
- cyc_o in RESP/IDLE: 0 unless the last command had cmd_hold=1 and status 00; then cyc_o stays 1, stb_o=0 until a command with hold=0 ends or an abort occurs.
- Locked with FIFO empty: cyc_o=1, stb_o=0 indefinitely (no timeout).
- Outside REQ, adr_o/dat_o/sel_o/we_o hold their last values; stb_o is 0.
- Reset mid-cycle: cyc_o/stb_o drop asynchronously; queued commands and the pending response are discarded.

Decomposition:
- Package wb_master_seq_pkg: status encodings (ST_OK, ST_ERR, ST_RTY, ST_TMO), state encoding, clog2 function.
- Sub-module wb_cmd_fifo: synchronous show-ahead FIFO (width AW+DW+DW/8+2, depth CMD_DEPTH, async active-low reset, full/empty flags).

Test Plan:
- Write 0x04 data 0xA5A5_0001 sel 0xF, slave acks after 1 wait state -> exactly 2 cycles with stb_o=1; we_o=1; rsp status 00, rsp_dat 0.
- Read 0x08, slave returns 0x1234_5678 with ack -> rsp_dat 0x12345678, status 00; cyc_o low the cycle after ack.
- MAX_RETRY=3: slave rty twice, then ack -> 2 gaps of 2 cycles with cyc_o=0; rsp_retries=2, status 00. Slave rty 4 times -> status 10, retries 3.
- TIMEOUT=64, slave silent -> cyc_o drops after 64 REQ cycles; status 11; next queued command proceeds.
- Commands hold=1, hold=1, hold=0, all acked -> cyc_o continuously high across all three; stb_o low between them; cyc_o low after the third.
- Push 5 commands with rsp_ready=0 and CMD_DEPTH=4 -> cmd_ready=0 at full. Assert rst_n=0 mid-REQ -> all outputs 0 immediately; busy=0 after release.

Source files
------------

// File: rtl/wb_master_seq_pkg.sv
// Shared encodings and sizing helpers for the Wishbone command sequencer.
package wb_master_seq_pkg;

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_ERR = 2'b01;
    localparam logic [1:0] ST_RTY = 2'b10;
    localparam logic [1:0] ST_TMO = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_GAP,
        S_RESP
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Bits needed to count 0..max_val, never less than one.
    function automatic int width_of(input int max_val);
        return (clog2(max_val + 1) < 1) ? 1 : clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/wb_cmd_fifo.sv
// Show-ahead command FIFO: head word visible on pop_dat while not empty.
// Push while full and pop while empty are ignored.
module wb_cmd_fifo
    import wb_master_seq_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);
    localparam int PW = clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign pop_dat = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[PW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/wb_master_seq.sv
// Command-driven Wishbone classic master: queued single beats, retry, watchdog, locked cycles.
// One response per command; sequencer stalls in RESP until rsp_ready, cmd_ready drops when queue full.
module wb_master_seq
    import wb_master_seq_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int CMD_DEPTH = 4,
    parameter int MAX_RETRY = 3,
    parameter int RETRY_GAP = 2,
    parameter int TIMEOUT   = 64,
    localparam int RW       = width_of(MAX_RETRY)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic            cmd_hold,
    input  logic [AW-1:0]   cmd_adr,
    input  logic [DW-1:0]   cmd_dat,
    input  logic [DW/8-1:0] cmd_sel,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_dat,
    output logic [1:0]      rsp_status,
    output logic [RW-1:0]   rsp_retries,
    output logic            busy,
    output logic [AW-1:0]   adr_o,
    output logic [DW-1:0]   dat_o,
    output logic [DW/8-1:0] sel_o,
    output logic            we_o,
    output logic            cyc_o,
    output logic            stb_o,
    input  logic [DW-1:0]   dat_i,
    input  logic            ack_i,
    input  logic            err_i,
    input  logic            rty_i
);
    localparam int SW = DW / 8;
    localparam int FW = AW + DW + SW + 2;
    localparam int WW = width_of(TIMEOUT);
    localparam int GW = width_of(RETRY_GAP);

    localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RETRY);
    localparam logic [WW-1:0] WD_LAST  = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [GW-1:0] GAP_LAST = GW'(RETRY_GAP - 1);

    logic          rdy_q;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic [FW-1:0] fifo_dat;

    state_t        state_q, state_d;
    logic [AW-1:0] adr_d;
    logic [DW-1:0] dat_d;
    logic [SW-1:0] sel_d;
    logic          we_d, cyc_d, stb_d;
    logic          hold_q, hold_d;
    logic          lock_q, lock_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [WW-1:0] wd_q, wd_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          rsp_valid_d;
    logic [DW-1:0] rsp_dat_d;
    logic [1:0]    rsp_status_d;
    logic [RW-1:0] rsp_retries_d;
    logic          abort;
    logic [1:0]    abort_st;

    // rdy_q keeps cmd_ready low during reset and for the first edge after release.
    assign cmd_ready = rdy_q && !fifo_full;
    assign busy      = !fifo_empty || (state_q != S_IDLE);

    wb_cmd_fifo #(
        .W     (FW),
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (cmd_valid && cmd_ready),
        .push_dat ({cmd_we, cmd_hold, cmd_adr, cmd_dat, cmd_sel}),
        .pop      (pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        state_d       = state_q;
        adr_d         = adr_o;
        dat_d         = dat_o;
        sel_d         = sel_o;
        we_d          = we_o;
        cyc_d         = cyc_o;
        stb_d         = stb_o;
        hold_d        = hold_q;
        lock_d        = lock_q;
        retry_d       = retry_q;
        wd_d          = wd_q;
        gap_d         = gap_q;
        rsp_valid_d   = rsp_valid;
        rsp_dat_d     = rsp_dat;
        rsp_status_d  = rsp_status;
        rsp_retries_d = rsp_retries;
        pop           = 1'b0;
        abort         = 1'b0;
        abort_st      = ST_OK;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    {we_d, hold_d, adr_d, dat_d, sel_d} = fifo_dat;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    retry_d = '0;
                    wd_d    = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (err_i) begin
                    abort    = 1'b1;
                    abort_st = ST_ERR;
                end else if (rty_i && (retry_q < RTY_MAX)) begin
                    retry_d = retry_q + 1'b1;
                    stb_d   = 1'b0;
                    cyc_d   = lock_q;
                    gap_d   = '0;
                    state_d = S_GAP;
                end else if (rty_i) begin
                    abort    = 1'b1;
                    abort_st = ST_RTY;
                end else if (ack_i) begin
                    stb_d         = 1'b0;
                    cyc_d         = hold_q;
                    lock_d        = hold_q;
                    rsp_valid_d   = 1'b1;
                    rsp_dat_d     = we_o ? '0 : dat_i;
                    rsp_status_d  = ST_OK;
                    rsp_retries_d = retry_q;
                    state_d       = S_RESP;
                end else if ((TIMEOUT != 0) && (wd_q == WD_LAST)) begin
                    abort    = 1'b1;
                    abort_st = ST_TMO;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    wd_d    = '0;
                    state_d = S_REQ;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Every abnormal termination also releases any bus lock.
        if (abort) begin
            stb_d         = 1'b0;
            cyc_d         = 1'b0;
            lock_d        = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_dat_d     = '0;
            rsp_status_d  = abort_st;
            rsp_retries_d = retry_q;
            state_d       = S_RESP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q       <= 1'b0;
            state_q     <= S_IDLE;
            adr_o       <= '0;
            dat_o       <= '0;
            sel_o       <= '0;
            we_o        <= 1'b0;
            cyc_o       <= 1'b0;
            stb_o       <= 1'b0;
            hold_q      <= 1'b0;
            lock_q      <= 1'b0;
            retry_q     <= '0;
            wd_q        <= '0;
            gap_q       <= '0;
            rsp_valid   <= 1'b0;
            rsp_dat     <= '0;
            rsp_status  <= ST_OK;
            rsp_retries <= '0;
        end else begin
            rdy_q       <= 1'b1;
            state_q     <= state_d;
            adr_o       <= adr_d;
            dat_o       <= dat_d;
            sel_o       <= sel_d;
            we_o        <= we_d;
            cyc_o       <= cyc_d;
            stb_o       <= stb_d;
            hold_q      <= hold_d;
            lock_q      <= lock_d;
            retry_q     <= retry_d;
            wd_q        <= wd_d;
            gap_q       <= gap_d;
            rsp_valid   <= rsp_valid_d;
            rsp_dat     <= rsp_dat_d;
            rsp_status  <= rsp_status_d;
            rsp_retries <= rsp_retries_d;
        end
    end

endmodule

// File: tb/tb_wb_master_seq.sv
// Directed bench for wb_master_seq with a configurable Wishbone slave responder.
module tb_wb_master_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0, cmd_hold = 1'b0;
    logic [31:0] cmd_adr = '0, cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic [1:0]  rsp_status, rsp_retries;
    logic        busy;
    logic [31:0] adr_o, dat_o;
    logic [3:0]  sel_o;
    logic        we_o, cyc_o, stb_o;
    logic [31:0] dat_i = '0;
    logic        ack_i = 1'b0, err_i = 1'b0, rty_i = 1'b0;

    int checks = 0;
    int errors = 0;

    int          sl_wait   = 0;
    int          sl_rty    = 0;
    bit          sl_silent = 1'b0;
    bit          sl_err    = 1'b0;
    logic [31:0] sl_rdata  = '0;
    int          wcnt      = 0;

    always #5 clk = ~clk;

    wb_master_seq dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_hold(cmd_hold),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
        .rsp_status(rsp_status), .rsp_retries(rsp_retries), .busy(busy),
        .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o), .we_o(we_o), .cyc_o(cyc_o), .stb_o(stb_o),
        .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i)
    );

    // Slave: after sl_wait wait states, answer rty sl_rty times, then err or ack.
    always @(negedge clk) begin
        ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0; dat_i = '0;
        if (rst_n && cyc_o && stb_o) begin
            if (wcnt < sl_wait) wcnt++;
            else if (!sl_silent) begin
                wcnt = 0;
                if (sl_rty > 0) begin rty_i = 1'b1; sl_rty--; end
                else if (sl_err) err_i = 1'b1;
                else begin ack_i = 1'b1; dat_i = sl_rdata; end
            end
        end else wcnt = 0;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout sim time exceeded");
        $fatal(1);
    end

    task automatic push(input bit we, input bit hold, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, output bit acc);
        acc = cmd_ready;
        cmd_valid = 1'b1; cmd_we = we; cmd_hold = hold; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge where rsp_valid is first seen.
    task automatic wait_rsp(input int limit, input bit seen0, output int n_stb, output int n_cyclo,
                            output int first, output bit to);
        bit seen;
        seen = seen0; n_stb = 0; n_cyclo = 0; first = -1; to = 1'b1;
        for (int i = 0; i < limit; i++) begin
            if (rsp_valid) begin to = 1'b0; break; end
            if (stb_o) begin
                if (first < 0) first = i;
                seen = 1'b1;
                n_stb++;
            end else if (seen && !cyc_o) n_cyclo++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if ({cyc_o, stb_o, we_o} !== 3'b000) begin errors++; $display("FAIL rst_bus_ctl got %b exp 000", {cyc_o, stb_o, we_o}); end
        checks++; if ({adr_o, dat_o, sel_o} !== 68'h0) begin errors++; $display("FAIL rst_bus_dat got %h exp 0", {adr_o, dat_o, sel_o}); end
        checks++; if ({cmd_ready, busy, rsp_valid} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {cmd_ready, busy, rsp_valid}); end
        checks++; if ({rsp_dat, rsp_status, rsp_retries} !== 36'h0) begin errors++; $display("FAIL rst_rsp got %h exp 0", {rsp_dat, rsp_status, rsp_retries}); end
        rst_n = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rdy_at_release got %b exp 0", cmd_ready); end
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rdy_after_release got %b exp 1", cmd_ready); end
    endtask

    task automatic test_read();
        bit acc, to; int ns, nc, fs;
        sl_wait = 0; sl_rdata = 32'h1234_5678;
        push(1'b0, 1'b0, 32'h8, 32'h0, 4'hF, acc);
        wait_rsp(20, 1'b0, ns, nc, fs, to);
        checks++; if (to) begin errors++; $display("FAIL rd_rsp got timeout exp rsp_valid"); end
        checks++; if (rsp_dat !== 32'h1234_5678) begin errors++; $display("FAIL rd_dat got %h exp 12345678", rsp_dat); end
        checks++; if (rsp_status !== 2'b00) begin errors++; $display("FAIL rd_status got %b exp 00", rsp_status); end
        checks++; if ({cyc_o, stb_o} !== 2'b00) begin errors++; $display("FAIL rd_cyc_after_ack got %b exp 00", {cyc_o, stb_o}); end
        checks++; if ({ns, fs} !== {32'd1, 32'd1}) begin errors++; $display("FAIL rd_stb got cycles %0d first %0d exp 1 1", ns, fs); end
        checks++; if ({we_o, adr_o} !== {1'b0, 32'h8}) begin errors++; $display("FAIL rd_bus got %h exp 0_00000008", {we_o, adr_o}); end
        take_rsp();
        checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL rd_after_hs got %b exp 00", {rsp_valid, busy}); end
    endtask

    task automatic test_write();
        bit acc, to; int ns, nc, fs;
        sl_wait = 1; sl_rdata = 32'hDEAD_BEEF;
        push(1'b1, 1'b0, 32'h4, 32'hA5A5_0001, 4'hF, acc);
        checks++; if (stb_o !== 1'b0) begin errors++; $display("FAIL wr_stb_early got %b exp 0", stb_o); end
        wait_rsp(20, 1'b0, ns, nc, fs, to);
        checks++; if (to) begin errors++; $display("FAIL wr_rsp got timeout exp rsp_valid"); end
        checks++; if ({ns, fs} !== {32'd2, 32'd1}) begin errors++; $display("FAIL wr_stb got cycles %0d first %0d exp 2 1", ns, fs); end
        checks++; if ({we_o, adr_o, dat_o, sel_o} !== {1'b1, 32'h4, 32'hA5A5_0001, 4'hF}) begin errors++; $display("FAIL wr_bus got %h exp 1_00000004_a5a50001_f", {we_o, adr_o, dat_o, sel_o}); end
        checks++; if ({rsp_status, rsp_dat} !== 34'h0) begin errors++; $display("FAIL wr_rsp got status %b dat %h exp 00 0", rsp_status, rsp_dat); end
        take_rsp();
    endtask

    task automatic test_retry();
        bit acc, to; int ns, nc, fs;
        sl_wait = 0; sl_rty = 2; sl_rdata = 32'h0000_00C3;
        push(1'b0, 1'b0, 32'hC, 32'h0, 4'hF, acc);
        wait_rsp(40, 1'b0, ns, nc, fs, to);
        checks++; if (to) begin errors++; $display("FAIL rty2_rsp got timeout exp rsp_valid"); end
        checks++; if ({rsp_status, rsp_retries} !== 4'b0010) begin errors++; $display("FAIL rty2_st got status %b retries %0d exp 00 2", rsp_status, rsp_retries); end
        checks++; if ({ns, nc} !== {32'd3, 32'd4}) begin errors++; $display("FAIL rty2_gaps got stb %0d cyc_lo %0d exp 3 4", ns, nc); end
        checks++; if (rsp_dat !== 32'h0000_00C3) begin errors++; $display("FAIL rty2_dat got %h exp 000000c3", rsp_dat); end
        take_rsp();
        sl_rty = 4;
        push(1'b1, 1'b0, 32'h10, 32'h5, 4'h1, acc);
        wait_rsp(40, 1'b0, ns, nc, fs, to);
        checks++; if (to) begin errors++; $display("FAIL rty4_rsp got timeout exp rsp_valid"); end
        checks++; if ({rsp_status, rsp_retries} !== 4'b1011) begin errors++; $display("FAIL rty4_st got status %b retries %0d exp 10 3", rsp_status, rsp_retries); end
        checks++; if ({ns, nc} !== {32'd4, 32'd6}) begin errors++; $display("FAIL rty4_gaps got stb %0d cyc_lo %0d exp 4 6", ns, nc); end
        sl_rty = 0;
        take_rsp();
    endtask

    task automatic test_timeout();
        bit acc, to; int ns, nc, fs;
        sl_wait = 0; sl_silent = 1'b1; sl_rdata = 32'h0BAD_F00D;
        push(1'b1, 1'b0, 32'h20, 32'h1, 4'hF, acc);
        push(1'b0, 1'b0, 32'h24, 32'h0, 4'hF, acc);
        wait_rsp(100, 1'b1, ns, nc, fs, to);
        checks++; if (to) begin errors++; $display("FAIL tmo_rsp got timeout exp rsp_valid"); end
        checks++; if (ns !== 64) begin errors++; $display("FAIL tmo_req_cycles got %0d exp 64", ns); end
        checks++; if ({rsp_status, cyc_o, stb_o} !== 4'b1100) begin errors++; $display("FAIL tmo_st got status %b cyc %b stb %b exp 11 0 0", rsp_status, cyc_o, stb_o); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tmo_busy got %b exp 1", busy); end
        sl_silent = 1'b0;
        take_rsp();
        wait_rsp(20, 1'b0, ns, nc, fs, to);
        checks++; if (to) begin errors++; $display("FAIL tmo_next got timeout exp rsp_valid"); end
        checks++; if ({rsp_status, rsp_dat} !== {2'b00, 32'h0BAD_F00D}) begin errors++; $display("FAIL tmo_next_rsp got %b %h exp 00 0badf00d", rsp_status, rsp_dat); end
        take_rsp();
    endtask

    task automatic test_lock();
        bit acc, to; int ns, nc, fs;
        sl_wait = 0; sl_rdata = 32'h55AA_55AA;
        push(1'b1, 1'b1, 32'h30, 32'h11, 4'hF, acc);
        push(1'b1, 1'b1, 32'h34, 32'h22, 4'hF, acc);
        push(1'b0, 1'b0, 32'h38, 32'h0, 4'hF, acc);
        wait_rsp(20, 1'b0, ns, nc, fs, to);
        checks++; if ({to, rsp_status, cyc_o, stb_o} !== 5'b00010) begin errors++; $display("FAIL lock_a got to %b st %b cyc %b stb %b exp 0 00 1 0", to, rsp_status, cyc_o, stb_o); end
        take_rsp();
        wait_rsp(20, 1'b1, ns, nc, fs, to);
        checks++; if ({to, cyc_o, stb_o} !== 3'b010) begin errors++; $display("FAIL lock_b got to %b cyc %b stb %b exp 0 1 0", to, cyc_o, stb_o); end
        checks++; if ({ns, nc} !== {32'd1, 32'd0}) begin errors++; $display("FAIL lock_b_cyc got stb %0d cyc_lo %0d exp 1 0", ns, nc); end
        take_rsp();
        wait_rsp(20, 1'b1, ns, nc, fs, to);
        checks++; if ({to, nc} !== {1'b0, 32'd0}) begin errors++; $display("FAIL lock_c_cyc got to %b cyc_lo %0d exp 0 0", to, nc); end
        checks++; if ({cyc_o, rsp_dat} !== {1'b0, 32'h55AA_55AA}) begin errors++; $display("FAIL lock_c_end got cyc %b dat %h exp 0 55aa55aa", cyc_o, rsp_dat); end
        take_rsp();
    endtask

    task automatic test_err_unlock();
        bit acc, to; int ns, nc, fs; int bad;
        sl_wait = 0;
        push(1'b1, 1'b1, 32'h40, 32'h33, 4'h3, acc);
        wait_rsp(20, 1'b0, ns, nc, fs, to);
        sl_err = 1'b1;
        take_rsp();
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (!(cyc_o && !stb_o)) bad++;
            @(negedge clk);
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL lock_idle got %0d bad cycles exp 0", bad); end
        push(1'b0, 1'b1, 32'h44, 32'h0, 4'hF, acc);
        wait_rsp(20, 1'b1, ns, nc, fs, to);
        checks++; if ({to, rsp_status, cyc_o} !== 4'b0010) begin errors++; $display("FAIL err_unlock got to %b st %b cyc %b exp 0 01 0", to, rsp_status, cyc_o); end
        sl_err = 1'b0;
        take_rsp();
    endtask

    task automatic test_full_and_reset();
        bit acc; int n_acc;
        sl_silent = 1'b1; n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            push(1'b1, 1'b0, 32'h50 + 32'(i), 32'(i), 4'hF, acc);
            if (acc) n_acc++;
        end
        checks++; if (n_acc !== 5) begin errors++; $display("FAIL full_accepted got %0d exp 5", n_acc); end
        checks++; if ({cmd_ready, busy, stb_o} !== 3'b011) begin errors++; $display("FAIL full_flags got %b exp 011", {cmd_ready, busy, stb_o}); end
        push(1'b1, 1'b0, 32'h60, 32'h6, 4'hF, acc);
        checks++; if (acc !== 1'b0) begin errors++; $display("FAIL full_push got %b exp 0", acc); end
        rst_n = 1'b0;
        #1;
        checks++; if ({cyc_o, stb_o, we_o, busy, cmd_ready, rsp_valid} !== 6'b0) begin errors++; $display("FAIL midrst_ctl got %b exp 000000", {cyc_o, stb_o, we_o, busy, cmd_ready, rsp_valid}); end
        checks++; if ({adr_o, dat_o, sel_o} !== 68'h0) begin errors++; $display("FAIL midrst_bus got %h exp 0", {adr_o, dat_o, sel_o}); end
        @(negedge clk);
        rst_n = 1'b1; sl_silent = 1'b0;
        @(negedge clk);
        checks++; if ({cmd_ready, busy} !== 2'b10) begin errors++; $display("FAIL post_rst got %b exp 10", {cmd_ready, busy}); end
        repeat (3) @(negedge clk);
        checks++; if ({stb_o, cyc_o, busy, rsp_valid} !== 4'b0) begin errors++; $display("FAIL discard got %b exp 0000", {stb_o, cyc_o, busy, rsp_valid}); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_retry();
        test_timeout();
        test_lock();
        test_err_unlock();
        test_full_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
